// File: rtl/water_dispenser_pkg.sv
// Shared types and helpers for the water dispenser front-panel controller.
// The optional INPUT_SYNC_EN macro (see water_dispenser.sv) adds input synchronizers.
package water_dispenser_pkg;

    localparam int AMOUNT_W  = 32;
    localparam int SEL_MAX_W = 32;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        DISPENSING = 1'b1
    } state_t;

    // Index of the highest set bit; a vector with no bits set selects 0.
    function automatic logic [AMOUNT_W-1:0] highest_set(input logic [SEL_MAX_W-1:0] vec);
        logic [AMOUNT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < SEL_MAX_W; i++) begin
            if (vec[i]) idx = AMOUNT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/water_dispenser_rise_detect.sv
// Rising-edge detector for a level button; history resets to 1 so a button
// held across reset release never counts as a press.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples its inputs from before the clock edge.
    always_ff @(posedge clock) begin
        if (reset) prev <= 1'b1;
        else       prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/water_dispenser.sv
// Water dispenser panel controller: accumulates selected volumes, dispenses one
// unit per DISPENSE_TICKS cycles, cancel clears. Define INPUT_SYNC_EN for 2-flop input synchronizers.
module water_dispenser
    import water_dispenser_pkg::*;
#(
    parameter int SWITCH_COUNT   = 10,
    parameter int MAX_TOTAL      = 20,
    parameter int DISPENSE_TICKS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SWITCH_COUNT-1:0] switches,
    input  logic                    button_add,
    input  logic                    button_ok,
    input  logic                    button_cancel,
    output logic [AMOUNT_W-1:0]     total_amount
);

    localparam int TICK_W = (DISPENSE_TICKS > 1) ? $clog2(DISPENSE_TICKS) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(DISPENSE_TICKS - 1);
    localparam logic [AMOUNT_W:0]  MAX_EXT   = (AMOUNT_W + 1)'(MAX_TOTAL);

    logic [SWITCH_COUNT-1:0] sw_s;
    logic                    add_s, ok_s, cancel_s;

`ifdef INPUT_SYNC_EN
    logic [SWITCH_COUNT-1:0] sw_meta, sw_sync;
    logic [2:0]              btn_meta, btn_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= switches;
            sw_sync  <= sw_meta;
            btn_meta <= {button_cancel, button_ok, button_add};
            btn_sync <= btn_meta;
        end
    end

    assign sw_s     = sw_sync;
    assign add_s    = btn_sync[0];
    assign ok_s     = btn_sync[1];
    assign cancel_s = btn_sync[2];
`else
    assign sw_s     = switches;
    assign add_s    = button_add;
    assign ok_s     = button_ok;
    assign cancel_s = button_cancel;
`endif

    logic add_rise, ok_rise, cancel_rise;

    rise_detect u_add_rise    (.clock(clock), .reset(reset), .level(add_s),    .rise(add_rise));
    rise_detect u_ok_rise     (.clock(clock), .reset(reset), .level(ok_s),     .rise(ok_rise));
    rise_detect u_cancel_rise (.clock(clock), .reset(reset), .level(cancel_s), .rise(cancel_rise));

    logic [AMOUNT_W-1:0] sel;
    logic [AMOUNT_W:0]   sum_ext;
    logic [AMOUNT_W-1:0] sat_sum;

    // Sum is one bit wider than the total so saturation sees the true value.
    assign sel     = highest_set(SEL_MAX_W'(sw_s));
    assign sum_ext = {1'b0, total_amount} + {1'b0, sel};
    assign sat_sum = (sum_ext > MAX_EXT) ? AMOUNT_W'(MAX_TOTAL) : sum_ext[AMOUNT_W-1:0];

    state_t              state, state_next;
    logic [TICK_W-1:0]   tick, tick_next;
    logic [AMOUNT_W-1:0] total_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            tick         <= '0;
            total_amount <= '0;
        end else begin
            state        <= state_next;
            tick         <= tick_next;
            total_amount <= total_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        tick_next  = tick;
        total_next = total_amount;

        if (cancel_rise) begin
            state_next = IDLE;
            tick_next  = '0;
            total_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ok_rise) begin
                        if (total_amount != '0) begin
                            state_next = DISPENSING;
                            tick_next  = '0;
                        end
                    end else if (add_rise) begin
                        total_next = sat_sum;
                    end
                end
                DISPENSING: begin
                    // Add and ok are ignored while dispensing; only the tick advances.
                    if (tick == TICK_LAST) begin
                        tick_next = '0;
                        if (total_amount != '0) total_next = total_amount - 1'b1;
                        if (total_amount <= AMOUNT_W'(1)) state_next = IDLE;
                    end else begin
                        tick_next = tick + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    tick_next  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_water_dispenser.sv
// Self-checking bench for water_dispenser: a cycle-level behavioural model
// checked every cycle, plus hand-computed totals at key points.
module tb_water_dispenser;

    localparam int SWITCH_COUNT   = 10;
    localparam int MAX_TOTAL      = 20;
    localparam int DISPENSE_TICKS = 4;

    logic                    clock;
    logic                    reset;
    logic [SWITCH_COUNT-1:0] switches;
    logic                    button_add;
    logic                    button_ok;
    logic                    button_cancel;
    logic [31:0]             total_amount;

    int checks   = 0;
    int failures = 0;

    water_dispenser #(
        .SWITCH_COUNT  (SWITCH_COUNT),
        .MAX_TOTAL     (MAX_TOTAL),
        .DISPENSE_TICKS(DISPENSE_TICKS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .switches     (switches),
        .button_add   (button_add),
        .button_ok    (button_ok),
        .button_cancel(button_cancel),
        .total_amount (total_amount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the total as a plain integer plus a countdown to the next unit leaving.
    int m_total;
    bit m_dispensing;
    int m_cycles_left;
    bit m_prev_add, m_prev_ok, m_prev_cancel;
    bit model_live = 0;

    always @(posedge clock) begin
        bit p_add, p_ok, p_cancel;
        int sel;
        if (reset) begin
            m_total       = 0;
            m_dispensing  = 0;
            m_cycles_left = 0;
            m_prev_add    = 1;
            m_prev_ok     = 1;
            m_prev_cancel = 1;
            model_live    = 1;
        end else begin
            p_add    = button_add    && !m_prev_add;
            p_ok     = button_ok     && !m_prev_ok;
            p_cancel = button_cancel && !m_prev_cancel;
            m_prev_add    = button_add;
            m_prev_ok     = button_ok;
            m_prev_cancel = button_cancel;
            sel = 0;
            for (int i = 0; i < SWITCH_COUNT; i++) if (switches[i]) sel = i;

            if (p_cancel) begin
                m_total      = 0;
                m_dispensing = 0;
            end else if (m_dispensing) begin
                m_cycles_left--;
                if (m_cycles_left == 0) begin
                    m_total--;
                    m_cycles_left = DISPENSE_TICKS;
                    if (m_total == 0) m_dispensing = 0;
                end
            end else if (p_ok) begin
                if (m_total > 0) begin
                    m_dispensing  = 1;
                    m_cycles_left = DISPENSE_TICKS;
                end
            end else if (p_add) begin
                m_total = (m_total + sel > MAX_TOTAL) ? MAX_TOTAL : m_total + sel;
            end
        end
    end

    always @(negedge clock) begin
        if (model_live) check("model_total", total_amount, 32'(m_total));
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [SWITCH_COUNT-1:0] onehot(input int i);
        logic [SWITCH_COUNT-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic press_add(input logic [SWITCH_COUNT-1:0] sw);
        switches   = sw;
        button_add = 1'b1;
        cycles(1);
        button_add = 1'b0;
        cycles(1);
    endtask

    task automatic press_ok();
        button_ok = 1'b1;
        cycles(1);
        button_ok = 1'b0;
    endtask

    task automatic press_cancel();
        button_cancel = 1'b1;
        cycles(1);
        button_cancel = 1'b0;
        cycles(1);
    endtask

    initial begin
        reset         = 1'b1;
        switches      = '0;
        button_add    = 1'b0;
        button_ok     = 1'b0;
        button_cancel = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(10);
        check("idle_after_reset", total_amount, 32'd0);

        // Holding add for several cycles is a single press.
        switches   = onehot(1);
        button_add = 1'b1;
        cycles(3);
        button_add = 1'b0;
        cycles(1);
        check("single_add_held", total_amount, 32'd1);

        press_add(onehot(9));
        check("add_9", total_amount, 32'd10);
        press_add(onehot(9));
        check("add_9_again", total_amount, 32'd19);
        press_add(onehot(3));
        check("saturate_20", total_amount, 32'd20);
        press_add(onehot(5));
        check("stay_saturated", total_amount, 32'd20);

        // Dispense 3 units at one per 4 cycles, with an ignored add in the middle.
        press_cancel();
        check("cancel_idle", total_amount, 32'd0);
        press_add(onehot(3));
        press_ok();
        check("disp_start", total_amount, 32'd3);
        cycles(3);
        check("disp_before_first", total_amount, 32'd3);
        cycles(1);
        check("disp_first_unit", total_amount, 32'd2);
        press_add(onehot(9));
        cycles(2);
        check("disp_add_ignored", total_amount, 32'd1);
        cycles(4);
        check("disp_done", total_amount, 32'd0);
        press_add(onehot(2));
        check("idle_after_dispense", total_amount, 32'd2);

        // ok and cancel on the same edge: cancel wins.
        press_cancel();
        press_add(onehot(9));
        press_add(onehot(3));
        check("total_12", total_amount, 32'd12);
        button_ok     = 1'b1;
        button_cancel = 1'b1;
        cycles(1);
        button_ok     = 1'b0;
        button_cancel = 1'b0;
        cycles(1);
        check("ok_cancel_same", total_amount, 32'd0);
        press_add(onehot(1));
        check("idle_after_ok_cancel", total_amount, 32'd1);

        // Cancel mid-dispense, then ok with an empty total does nothing.
        press_add(onehot(4));
        check("total_5", total_amount, 32'd5);
        press_ok();
        cycles(2);
        check("disp_5_running", total_amount, 32'd5);
        button_cancel = 1'b1;
        cycles(1);
        check("cancel_mid_dispense", total_amount, 32'd0);
        button_cancel = 1'b0;
        cycles(1);
        press_ok();
        cycles(6);
        check("ok_on_zero", total_amount, 32'd0);
        press_add(onehot(2));
        check("idle_after_ok_zero", total_amount, 32'd2);

        // Add held across reset release is not a press.
        switches   = onehot(5);
        button_add = 1'b1;
        reset      = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(3);
        check("add_held_over_reset", total_amount, 32'd0);
        button_add = 1'b0;
        cycles(2);

        // Selector: no switch, multiple switches, switch 0 only.
        press_add(onehot(3));
        press_add('0);
        check("no_switch_add", total_amount, 32'd3);
        press_add(10'b00_0001_0110);
        check("highest_switch_wins", total_amount, 32'd7);
        press_add(onehot(0));
        check("switch0_adds_zero", total_amount, 32'd7);

        // ok and add together in idle: ok wins, then reset mid-dispense.
        switches   = onehot(5);
        button_ok  = 1'b1;
        button_add = 1'b1;
        cycles(1);
        button_ok  = 1'b0;
        button_add = 1'b0;
        check("ok_beats_add", total_amount, 32'd7);
        cycles(4);
        check("dispense_after_ok_add", total_amount, 32'd6);
        reset = 1'b1;
        cycles(1);
        check("reset_mid_dispense", total_amount, 32'd0);
        reset = 1'b0;
        cycles(6);
        check("idle_after_reset_abort", total_amount, 32'd0);

        cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
